// File: rtl/spi_flash_write_seq.sv
// SPI flash write sequencer: WR_EN -> PROG_PAGE/ERASE_SEC -> RD_ST_REG polling
// until WIP clears (or poll budget runs out) -> WR_DIS, with a done/err report.
module spi_flash_write_seq #(
  parameter logic [15:0] POLL_MAX = 16'd65535,
  parameter logic [7:0]  POLL_GAP = 8'd16
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        req_valid,
  input  logic        req_op,
  input  logic [23:0] req_addr,
  output logic        req_ready,
  output logic [4:0]  cmd_type,
  output logic [7:0]  cmd_code,
  output logic [23:0] cmd_addr,
  input  logic        cmd_done,
  input  logic [7:0]  cmd_rdata,
  input  logic        cmd_rvalid,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [7:0]  status
);

  typedef enum logic [3:0] {
    S_IDLE, S_WREN, S_WREN_W, S_OP, S_OP_W, S_POLL, S_POLL_W,
    S_GAP, S_WRDIS, S_WRDIS_W, S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_nxt;
  logic        r_op;
  logic [23:0] r_addr;
  logic        r_done_q;
  logic [15:0] r_poll_cnt;
  logic [7:0]  r_gap_cnt;
  logic        r_got;
  logic [7:0]  r_status;
  logic        r_err;
  logic        r_req_ready;
  logic        r_busy;
  logic        r_done;
  logic [4:0]  r_cmd_type;
  logic [7:0]  r_cmd_code;
  logic [23:0] r_cmd_addr;

  logic w_edge;
  logic w_wip;
  logic w_timeout;
  logic w_accept;

  always_comb begin
    w_edge    = cmd_done & ~r_done_q;
    // A poll with no status byte at all counts as still busy.
    w_wip     = cmd_rvalid ? cmd_rdata[0] : (r_got ? r_status[0] : 1'b1);
    w_timeout = (r_poll_cnt >= POLL_MAX);
    w_accept  = req_valid & r_req_ready;
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_accept) w_nxt = S_WREN;
      S_WREN:    w_nxt = S_WREN_W;
      S_WREN_W:  if (w_edge) w_nxt = S_OP;
      S_OP:      w_nxt = S_OP_W;
      S_OP_W:    if (w_edge) w_nxt = S_POLL;
      S_POLL:    w_nxt = S_POLL_W;
      S_POLL_W:
        if (w_edge) begin
          if (!w_wip || w_timeout) w_nxt = S_WRDIS;
          else if (POLL_GAP == 8'd0) w_nxt = S_POLL;
          else w_nxt = S_GAP;
        end
      S_GAP:     if (r_gap_cnt == POLL_GAP - 8'd1) w_nxt = S_POLL;
      S_WRDIS:   w_nxt = S_WRDIS_W;
      S_WRDIS_W: if (w_edge) w_nxt = S_DONE;
      S_DONE:    w_nxt = S_IDLE;
      default:   w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_state     <= S_IDLE;
      r_op        <= 1'b0;
      r_addr      <= 24'd0;
      r_done_q    <= 1'b0;
      r_poll_cnt  <= 16'd0;
      r_gap_cnt   <= 8'd0;
      r_got       <= 1'b0;
      r_status    <= 8'h00;
      r_err       <= 1'b0;
      r_req_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_cmd_type  <= 5'b00000;
      r_cmd_code  <= 8'h00;
      r_cmd_addr  <= 24'd0;
    end else begin
      r_state     <= w_nxt;
      r_done_q    <= cmd_done;
      r_req_ready <= (w_nxt == S_IDLE);
      r_busy      <= (w_nxt != S_IDLE);
      r_done      <= (w_nxt == S_DONE);
      r_gap_cnt   <= (r_state == S_GAP) ? r_gap_cnt + 8'd1 : 8'd0;
      if (w_accept) begin
        r_op       <= req_op;
        r_addr     <= req_addr;
        r_poll_cnt <= 16'd0;
        r_err      <= 1'b0;
      end
      if (r_state == S_POLL) begin
        r_got <= 1'b0;
        if (r_poll_cnt != 16'hFFFF) r_poll_cnt <= r_poll_cnt + 16'd1;
      end
      if (r_state == S_POLL_W && cmd_rvalid) begin
        r_status <= cmd_rdata;
        r_got    <= 1'b1;
      end
      if (r_state == S_POLL_W && w_edge && w_wip && w_timeout) r_err <= 1'b1;
      // Command bus is registered off the next state so it lines up with the issue cycle.
      case (w_nxt)
        S_WREN:  begin r_cmd_type <= 5'b10001; r_cmd_code <= 8'h06; r_cmd_addr <= 24'd0; end
        S_OP: begin
          r_cmd_type <= r_op ? 5'b10010 : 5'b10101;
          r_cmd_code <= r_op ? 8'h20 : 8'h02;
          r_cmd_addr <= r_addr;
        end
        S_POLL:  begin r_cmd_type <= 5'b10011; r_cmd_code <= 8'h05; r_cmd_addr <= 24'd0; end
        S_WRDIS: begin r_cmd_type <= 5'b10100; r_cmd_code <= 8'h04; r_cmd_addr <= 24'd0; end
        default: begin r_cmd_type <= 5'b00000; r_cmd_code <= 8'h00; r_cmd_addr <= 24'd0; end
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign status    = r_status;
  assign cmd_type  = r_cmd_type;
  assign cmd_code  = r_cmd_code;
  assign cmd_addr  = r_cmd_addr;

endmodule

// File: tb/tb_spi_flash_write_seq.sv
// Bench for spi_flash_write_seq: transaction-level model plus a flash-controller
// responder with random latencies, hold times and status bytes.
module tb_spi_flash_write_seq;

  localparam logic [15:0] PMAX = 16'd3;
  localparam int          GAP  = 16;
  localparam logic [4:0]  T_NONE = 5'b00000, T_WREN = 5'b10001, T_ERASE = 5'b10010,
                          T_RD = 5'b10011, T_WRDIS = 5'b10100, T_PROG = 5'b10101;

  logic        PCLK, PRESET, req_valid, req_op, req_ready, cmd_done, cmd_rvalid;
  logic        busy, done, err;
  logic [23:0] req_addr, cmd_addr;
  logic [4:0]  cmd_type;
  logic [7:0]  cmd_code, cmd_rdata, status;

  spi_flash_write_seq #(.POLL_MAX(PMAX), .POLL_GAP(8'd16)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .req_valid(req_valid), .req_op(req_op),
    .req_addr(req_addr), .req_ready(req_ready), .cmd_type(cmd_type),
    .cmd_code(cmd_code), .cmd_addr(cmd_addr), .cmd_done(cmd_done),
    .cmd_rdata(cmd_rdata), .cmd_rvalid(cmd_rvalid), .busy(busy), .done(done),
    .err(err), .status(status)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  int n_chk = 0, n_fail = 0, cyc = 0;
  bit chk_en = 0;

  // transaction model
  bit m_busy = 0, m_err = 0, waiting = 0, op_kind = 0, pgot = 0, acc_flag = 0, prev_cd = 0;
  logic [7:0] m_status = 8'h00, pbyte = 8'h00;
  int exp_at = -1, done_at = -1, polls = 0, acc_cyc = 0;
  logic [4:0] exp_cmd = T_NONE, cur = T_NONE;
  logic [23:0] exp_addr = 24'd0, op_addr = 24'd0;

  // responder and scenario knobs
  bit cd = 0, det = 1;
  int rise_at = -1, hi_until = -100, rv_at = -1, resp_h = 1, det_h = 1, nb = 0;
  logic [7:0] rv_byte = 8'h00;
  logic [7:0] script [4];

  // stimulus requests from the main sequence
  bit t_rv = 0, t_op = 0, t_rst = 1;
  logic [23:0] t_addr = 24'd0;

  // observed DUT command log
  logic [4:0] log_q [$];
  int log_cyc [$];
  int dut_done_cyc = -1;

  function automatic logic [7:0] code_of(input logic [4:0] t);
    case (t)
      T_WREN:  return 8'h06;
      T_ERASE: return 8'h20;
      T_RD:    return 8'h05;
      T_WRDIS: return 8'h04;
      T_PROG:  return 8'h02;
      default: return 8'h00;
    endcase
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
  endtask

  task automatic on_issue();
    logic [7:0] rb;
    int idx;
    int l;
    l       = det ? 2 : int'($urandom_range(1, 4));
    resp_h  = det ? det_h : int'($urandom_range(1, 10));
    rise_at = imax(cyc + l, hi_until + 2);
    rv_at   = -1;
    if (cur == T_RD) begin
      polls++;
      pgot = 0;
      if (det) begin
        idx = (polls > 4) ? 3 : polls - 1;
        rv_byte = script[idx];
        rv_at = rise_at;
      end else begin
        rb = 8'($urandom);
        rb[0] = (polls <= nb);
        rv_byte = rb;
        if (!(rb[0] && ($urandom_range(0, 3) == 0))) rv_at = int'($urandom_range(cyc + 1, rise_at));
      end
    end else if (!det && $urandom_range(0, 2) == 0) begin
      rv_byte = 8'($urandom);
      rv_at = int'($urandom_range(cyc + 1, rise_at));
    end
  endtask

  task automatic check();
    logic [4:0] et;
    logic [23:0] ea;
    if (!chk_en) return;
    et = T_NONE;
    ea = 24'd0;
    if (exp_at == cyc) begin
      et = exp_cmd;
      ea = exp_addr;
      waiting = 1;
      cur = exp_cmd;
      exp_at = -1;
      on_issue();
    end
    chk("cmd_type", 32'(cmd_type), 32'(et));
    chk("cmd_code", 32'(cmd_code), 32'(code_of(et)));
    chk("cmd_addr", 32'(cmd_addr), 32'(ea));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("req_ready", 32'(req_ready), 32'(!m_busy));
    chk("done", 32'(done), 32'(cyc == done_at));
    chk("err", 32'(err), 32'(m_err));
    chk("status", 32'(status), 32'(m_status));
    if (cmd_type !== T_NONE) begin
      log_q.push_back(cmd_type);
      log_cyc.push_back(cyc);
    end
    if (done === 1'b1) dut_done_cyc = cyc;
  endtask

  task automatic drive();
    PRESET    = t_rst;
    req_valid = t_rv;
    req_op    = t_op;
    req_addr  = t_addr;
    if (t_rst) begin
      cd = 0; rise_at = -1; hi_until = -100; rv_at = -1;
    end else if (cyc == rise_at) begin
      cd = 1;
      hi_until = cyc + resp_h - 1;
    end else if (cyc > hi_until) cd = 0;
    cmd_done   = cd;
    cmd_rvalid = (cyc == rv_at);
    cmd_rdata  = (cyc == rv_at) ? rv_byte : 8'($urandom);
  endtask

  task automatic update();
    bit edge_s, wip;
    edge_s = cmd_done && !prev_cd;
    prev_cd = cmd_done;
    if (PRESET) begin
      m_busy = 0; m_err = 0; m_status = 8'h00; exp_at = -1; done_at = -1;
      waiting = 0; prev_cd = 0; chk_en = 1;
      return;
    end
    if (!m_busy && req_valid) begin
      m_busy = 1; m_err = 0; exp_at = cyc + 1; exp_cmd = T_WREN; exp_addr = 24'd0;
      op_kind = req_op; op_addr = req_addr; polls = 0; acc_flag = 1; acc_cyc = cyc;
    end
    if (cyc == done_at) m_busy = 0;
    if (waiting && cur == T_RD && cmd_rvalid) begin
      m_status = cmd_rdata; pgot = 1; pbyte = cmd_rdata;
    end
    if (waiting && edge_s) begin
      waiting = 0;
      exp_addr = 24'd0;
      if (cur == T_WREN) begin
        exp_at = cyc + 1;
        exp_cmd = op_kind ? T_ERASE : T_PROG;
        exp_addr = op_addr;
      end else if (cur == T_PROG || cur == T_ERASE) begin
        exp_at = cyc + 1; exp_cmd = T_RD;
      end else if (cur == T_RD) begin
        wip = pgot ? pbyte[0] : 1'b1;
        if (!wip) begin
          exp_at = cyc + 1; exp_cmd = T_WRDIS;
        end else if (polls >= int'(PMAX)) begin
          m_err = 1; exp_at = cyc + 1; exp_cmd = T_WRDIS;
        end else begin
          exp_at = cyc + 1 + GAP; exp_cmd = T_RD;
        end
      end else if (cur == T_WRDIS) done_at = cyc + 1;
    end
  endtask

  task automatic cycle();
    @(negedge PCLK);
    cyc++;
    check();
    drive();
    update();
  endtask

  task automatic wait_accept();
    int n;
    n = 0;
    while (!acc_flag && n < 200) begin cycle(); n++; end
    if (!acc_flag) fail_now("accept");
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (m_busy && n < 3000) begin cycle(); n++; end
    if (m_busy) fail_now("op_finish");
  endtask

  task automatic run_op(input bit op, input logic [23:0] addr);
    t_op = op; t_addr = addr; t_rv = 1; acc_flag = 0; dut_done_cyc = -1;
    wait_accept();
    t_rv = 0;
    wait_idle();
    cycle();
  endtask

  task automatic chk_seq(input string name, input int base, input logic [4:0] s [6], input int n);
    chk({name, "_len"}, 32'(log_q.size() - base), 32'(n));
    for (int i = 0; i < n; i++)
      if (base + i < log_q.size()) chk({name, "_cmd"}, 32'(log_q[base + i]), 32'(s[i]));
  endtask

  initial begin
    int base, wren_n, wrdis_n, d1, rst_base, found;
    logic [4:0] s1 [6];
    PRESET = 1; req_valid = 0; req_op = 0; req_addr = 0; cmd_done = 0; cmd_rvalid = 0; cmd_rdata = 0;
    repeat (3) cycle();
    t_rst = 0;
    repeat (3) cycle();

    // program, polls 03, 03, 00
    det = 1; det_h = 1; script = '{8'h03, 8'h03, 8'h00, 8'h00};
    base = log_q.size();
    run_op(1'b0, 24'h001200);
    s1 = '{T_WREN, T_PROG, T_RD, T_RD, T_RD, T_WRDIS};
    chk_seq("prog_seq", base, s1, 6);
    if (log_cyc.size() > base) chk("wren_latency", 32'(log_cyc[base] - acc_cyc), 32'd1);
    chk("prog_duration", 32'(dut_done_cyc - acc_cyc), 32'd51);
    chk("prog_status", 32'(status), 32'h00);
    chk("prog_err", 32'(err), 32'd0);

    // erase with WIP stuck: timeout after exactly POLL_MAX polls
    script = '{8'h01, 8'h01, 8'h01, 8'h01};
    base = log_q.size();
    run_op(1'b1, 24'h0A0000);
    s1 = '{T_WREN, T_ERASE, T_RD, T_RD, T_RD, T_WRDIS};
    chk_seq("erase_seq", base, s1, 6);
    chk("erase_err", 32'(err), 32'd1);

    // long cmd_done hold, status 00 alongside the completion edge
    det_h = 10; script = '{8'h00, 8'h00, 8'h00, 8'h00};
    base = log_q.size();
    run_op(1'b0, 24'h00ABCD);
    s1 = '{T_WREN, T_PROG, T_RD, T_WRDIS, T_NONE, T_NONE};
    chk_seq("hold_seq", base, s1, 4);
    chk("hold_duration", 32'(dut_done_cyc - acc_cyc), 32'd37);
    chk("err_cleared", 32'(err), 32'd0);

    // req_valid held across a whole operation
    det = 0; nb = 1;
    base = log_q.size();
    t_op = 0; t_addr = 24'h123456; t_rv = 1; acc_flag = 0; dut_done_cyc = -1;
    wait_accept();
    acc_flag = 0; t_op = 1; t_addr = 24'h0B0000;
    wait_accept();
    d1 = dut_done_cyc;
    t_rv = 0;
    wait_idle();
    cycle();
    wren_n = 0; wrdis_n = 0;
    for (int i = base; i < log_q.size(); i++) begin
      if (log_q[i] == T_WREN) wren_n++;
      if (log_q[i] == T_WRDIS) wrdis_n++;
    end
    chk("held_wren_count", 32'(wren_n), 32'd2);
    chk("held_wrdis_count", 32'(wrdis_n), 32'd2);
    chk("held_reaccept", 32'(acc_cyc - d1), 32'd1);

    // reset while waiting for a status poll to complete
    nb = 2; t_op = 0; t_addr = 24'h00F000; t_rv = 1; acc_flag = 0;
    wait_accept();
    t_rv = 0;
    found = 0;
    for (int n = 0; n < 500 && !found; n++) begin
      cycle();
      if (waiting && cur == T_RD) found = 1;
    end
    if (!found) fail_now("reach_poll_wait");
    t_rst = 1; cycle(); t_rst = 0; cycle();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_status", 32'(status), 32'h00);
    rst_base = log_q.size();
    repeat (3) cycle();
    run_op(1'b1, 24'h030000);
    if (log_q.size() > rst_base) chk("restart_first_cmd", 32'(log_q[rst_base]), 32'(T_WREN));
    else fail_now("restart_log");

    // randomized operations
    for (int k = 0; k < 25; k++) begin
      nb = int'($urandom_range(0, 4));
      run_op(1'($urandom), 24'($urandom));
      repeat ($urandom_range(0, 3)) cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/spi_flash_write_seq.md
SPI_FLASH_WRITE_SEQ -- requirements
Module: spi_flash_write_seq

Interface
REQ-001 Parameter POLL_MAX, default 16'd65535: maximum read-status polls per operation before timeout.
REQ-002 Parameter POLL_GAP, default 8'd16: idle PCLK cycles between consecutive status polls.
REQ-003 PCLK  input  1  sole clock; all logic on the rising edge.
REQ-004 PRESET  input  1  reset, synchronous and active-high.
REQ-005 req_valid  input  1  operation request.
REQ-006 req_op  input  1  operation: 0 = program page, 1 = erase sector.
REQ-007 req_addr  input  24  flash byte address.
REQ-008 req_ready  output  1  sequencer idle; accepts a request.
REQ-009 cmd_type  output  5  command to the flash controller: NONE 00000, WR_EN 10001, ERASE_SEC 10010, RD_ST_REG 10011, WR_DIS 10100, PROG_PAGE 10101.
REQ-010 cmd_code  output  8  SPI opcode: 06 WR_EN, 20 ERASE_SEC, 05 RD_ST_REG, 04 WR_DIS, 02 PROG_PAGE, 00 none.
REQ-011 cmd_addr  output  24  command address; req_addr for PROG_PAGE and ERASE_SEC, else 0.
REQ-012 cmd_done  input  1  controller completion level; its rising edge marks completion.
REQ-013 cmd_rdata  input  8  read byte from the controller.
REQ-014 cmd_rvalid  input  1  cmd_rdata valid strobe.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle completion pulse.
REQ-017 err  output  1  timeout flag; valid with done, held until the next accept.
REQ-018 status  output  8  last status byte captured.

Function
REQ-019 The states SHALL be IDLE, WREN, WREN_W, OP, OP_W, POLL, POLL_W, GAP, WRDIS, WRDIS_W and DONE.
REQ-020 A request SHALL be accepted on a cycle with req_valid && req_ready; req_ready is 1 only in IDLE; req_op and req_addr are latched on accept.
REQ-021 Transitions SHALL be: IDLE->WREN on accept; WREN->WREN_W; WREN_W->OP on cmd_done edge; OP->OP_W; OP_W->POLL on edge; POLL->POLL_W; WRDIS->WRDIS_W; WRDIS_W->DONE on edge; DONE->IDLE.
REQ-022 Each issue state (WREN, OP, POLL, WRDIS) SHALL last exactly one cycle, during which cmd_type/cmd_code/cmd_addr carry that command; in all other states they are NONE/00/0.
REQ-023 OP SHALL issue PROG_PAGE (req_op=0) or ERASE_SEC (req_op=1) with the latched address.
REQ-024 The cmd_done edge SHALL be rising_edge = cmd_done && !cmd_done_q, with cmd_done_q registered; edges outside the _W states are ignored.
REQ-025 In POLL_W, status SHALL load cmd_rdata on every cmd_rvalid.
REQ-026 On the POLL_W edge, WIP SHALL be bit 0 of the cycle's cmd_rdata if cmd_rvalid is high in that cycle, else bit 0 of status; if no rvalid arrived during the poll, WIP = 1.
REQ-027 On the POLL_W edge, WIP=0 SHALL go to WRDIS; WIP=1 with poll count < POLL_MAX goes to GAP; WIP=1 with poll count = POLL_MAX sets err and goes to WRDIS.
REQ-028 The poll counter SHALL clear on accept and increment on each POLL issue cycle; it saturates and never wraps.
REQ-029 GAP SHALL last exactly POLL_GAP cycles and then go to POLL; POLL_GAP=0 goes straight to POLL.
REQ-030 done SHALL be 1 only in DONE; err clears on accept.
REQ-031 Accept-to-WR_EN-issue latency SHALL be 1 cycle; each issue state follows the preceding completion edge by 1 cycle.
REQ-032 A req_valid presented while busy SHALL be held off by req_ready=0 and not lost.

Reset
REQ-033 PRESET high at a rising PCLK edge SHALL force, at that edge regardless of state: IDLE, req_ready=1, busy=0, done=0, err=0, status=00, cmd_type=NONE, cmd_code=00, cmd_addr=0, cmd_done_q=0, poll counter=0.
REQ-034 Reset mid-operation SHALL abandon the sequence with no WR_DIS issued, and the next command seen by the controller is the one following a new accept.

Verification
REQ-035 Program at 0x001200; status polls return 03, 03, 00 -> commands WR_EN, PROG_PAGE@001200, RD_ST_REG x3 separated by GAP of 16 cycles, WR_DIS; done=1 with err=0, status=00.
REQ-036 Erase at 0x0A0000 with POLL_MAX=3 and WIP stuck at 1 -> exactly 3 RD_ST_REG, then WR_DIS; done with err=1; next accept clears err.
REQ-037 cmd_rvalid with 00 in the same cycle as the cmd_done rise -> no further poll, straight to WRDIS.
REQ-038 cmd_done held high for 10 cycles per command -> each command completes once; no double advance.
REQ-039 PRESET asserted in POLL_W -> next cycle IDLE with all outputs at reset values; a new request restarts at WR_EN.
REQ-040 req_valid held high across an entire operation -> second request accepted the cycle after DONE, with each command issued once per operation.
